// File: rtl/vote_recorder_if.sv
// ---------------------------------------------------------------------------
// vote_recorder_if
//
// Groups the signals between the voting-machine front panel and the vote
// recorder. Clock and reset are not part of the bundle; each side receives
// them as plain ports.
//
// Signals:
//   mode               0 = voting mode, 1 = result mode
//   button1..4_raw     raw candidate push-buttons (asynchronous, bouncy)
//   valid_vote_casted  one-cycle pulse when a vote is accepted
//   candidate1..4_vote saturating 8-bit tallies
//   multi_press_error  one-cycle pulse when a press is rejected as ambiguous
//   busy               high while the recorder is not ready for a new voter
//
// Modports:
//   master  front panel / stimulus side (drives mode and buttons)
//   slave   recorder side (drives tallies and status)
// ---------------------------------------------------------------------------
interface vote_recorder_if;

    logic       mode;
    logic       button1_raw;
    logic       button2_raw;
    logic       button3_raw;
    logic       button4_raw;

    logic       valid_vote_casted;
    logic [7:0] candidate1_vote;
    logic [7:0] candidate2_vote;
    logic [7:0] candidate3_vote;
    logic [7:0] candidate4_vote;
    logic       multi_press_error;
    logic       busy;

    modport master (
        output mode,
        output button1_raw,
        output button2_raw,
        output button3_raw,
        output button4_raw,
        input  valid_vote_casted,
        input  candidate1_vote,
        input  candidate2_vote,
        input  candidate3_vote,
        input  candidate4_vote,
        input  multi_press_error,
        input  busy
    );

    modport slave (
        input  mode,
        input  button1_raw,
        input  button2_raw,
        input  button3_raw,
        input  button4_raw,
        output valid_vote_casted,
        output candidate1_vote,
        output candidate2_vote,
        output candidate3_vote,
        output candidate4_vote,
        output multi_press_error,
        output busy
    );

endinterface

// File: rtl/vote_recorder.sv
// ---------------------------------------------------------------------------
// vote_recorder
//
// Capture side of the voting machine. Each raw candidate button is brought
// into the clock domain with a two-flop synchroniser, debounced, and
// edge-detected. A small FSM accepts at most one vote per voter session,
// rejects ambiguous multi-button presses, locks out further presses for a
// while after a vote, and then waits for every button to be released before
// the next voter may press.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronised-high cycles before a button
//                    counts as pressed (1..15)
//   LOCKOUT_CYCLES   cycles after an accepted vote during which all presses
//                    are ignored (1..255)
//
// Ports:
//   clock  system clock, rising edge active
//   reset  asynchronous, active-low; clears every register immediately
//   bus    vote_recorder_if.slave - mode and raw buttons in, tallies and
//          status pulses out (all outputs registered)
// ---------------------------------------------------------------------------
module vote_recorder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 10
) (
    input  logic             clock,
    input  logic             reset,
    vote_recorder_if.slave   bus
);

    localparam logic [3:0] DB_TARGET  = 4'(DEBOUNCE_CYCLES);
    localparam logic [7:0] LOCK_LOAD  = 8'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        LOCKOUT,
        WAIT_RELEASE
    } state_t;

    // -----------------------------------------------------------------------
    // Input path registers
    // -----------------------------------------------------------------------
    logic [3:0] button_raw;
    logic [3:0] sync_meta;
    logic [3:0] sync_q;
    logic [3:0] db_count [4];
    logic [3:0] db_level;
    logic [3:0] db_prev;
    logic [3:0] press;
    logic [3:0] other_db;
    logic [2:0] press_count;
    logic [1:0] press_sel;

    // -----------------------------------------------------------------------
    // FSM and datapath
    // -----------------------------------------------------------------------
    state_t     state;
    state_t     state_next;
    logic [7:0] lock_cnt;
    logic [7:0] lock_next;
    logic       vote_en;
    logic       err_en;
    logic [7:0] tally [4];
    logic       valid_q;
    logic       error_q;
    logic       busy_q;

    assign button_raw = {bus.button4_raw, bus.button3_raw,
                         bus.button2_raw, bus.button1_raw};

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= 4'b0000;
            sync_q    <= 4'b0000;
        end else begin
            sync_meta <= button_raw;
            sync_q    <= sync_meta;
        end
    end

    // Debounce counters count consecutive synchronised-high cycles and stop
    // at the target so a held button keeps its debounced level indefinitely.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                db_count[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!sync_q[i]) begin
                    db_count[i] <= 4'd0;
                end else if (db_count[i] != DB_TARGET) begin
                    db_count[i] <= db_count[i] + 4'd1;
                end
            end
        end
    end

    // The debounced level is gated by the synchroniser output so that a
    // release takes effect on the very first synchronised 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_level[i] = sync_q[i] && (db_count[i] == DB_TARGET);
        end
    end

    // Previous debounced level, used for the one-cycle press strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_prev <= 4'b0000;
        end else begin
            db_prev <= db_level;
        end
    end

    assign press       = db_level & ~db_prev;
    assign other_db    = db_level & ~press;
    assign press_count = {2'b00, press[0]} + {2'b00, press[1]}
                       + {2'b00, press[2]} + {2'b00, press[3]};

    // Index of the pressing button; only meaningful when exactly one press
    // strobe is active.
    always_comb begin
        press_sel = 2'd0;
        if (press[1]) begin
            press_sel = 2'd1;
        end else if (press[2]) begin
            press_sel = 2'd2;
        end else if (press[3]) begin
            press_sel = 2'd3;
        end
    end

    // State register and lockout counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lock_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_next;
        end
    end

    // Next-state logic. A press is only a vote when it is the sole press
    // strobe and no other button is already debounced high; anything else
    // seen in IDLE is treated as ambiguous and sends the FSM to wait for a
    // full release. Presses during LOCKOUT and WAIT_RELEASE are dropped
    // because the press strobe is a single-cycle edge.
    always_comb begin
        state_next = state;
        lock_next  = lock_cnt;
        vote_en    = 1'b0;
        err_en     = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.mode && (press != 4'b0000)) begin
                    if ((press_count == 3'd1) && (other_db == 4'b0000)) begin
                        vote_en    = 1'b1;
                        lock_next  = LOCK_LOAD;
                        state_next = LOCKOUT;
                    end else begin
                        err_en     = 1'b1;
                        state_next = WAIT_RELEASE;
                    end
                end
            end
            LOCKOUT: begin
                if (lock_cnt == 8'd0) begin
                    state_next = WAIT_RELEASE;
                end else begin
                    lock_next = lock_cnt - 8'd1;
                end
            end
            WAIT_RELEASE: begin
                if (db_level == 4'b0000) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Saturating tallies. A vote on a full tally is still a valid vote; the
    // count simply stays at its maximum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                tally[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (vote_en && (press_sel == 2'(i)) && (tally[i] != 8'hFF)) begin
                    tally[i] <= tally[i] + 8'd1;
                end
            end
        end
    end

    // Registered status outputs; busy follows the state being entered so
    // it lines up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= vote_en;
            error_q <= err_en;
            busy_q  <= (state_next != IDLE);
        end
    end

    assign bus.valid_vote_casted = valid_q;
    assign bus.multi_press_error = error_q;
    assign bus.busy              = busy_q;
    assign bus.candidate1_vote   = tally[0];
    assign bus.candidate2_vote   = tally[1];
    assign bus.candidate3_vote   = tally[2];
    assign bus.candidate4_vote   = tally[3];

endmodule

// File: tb/tb_vote_recorder.sv
// ---------------------------------------------------------------------------
// tb_vote_recorder
//
// Directed bench for vote_recorder with default parameters
// (DEBOUNCE_CYCLES = 4, LOCKOUT_CYCLES = 10). Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_vote_recorder;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int valid_seen  = 0;
    int error_seen  = 0;

    vote_recorder_if bus ();

    vote_recorder #(
        .DEBOUNCE_CYCLES (4),
        .LOCKOUT_CYCLES  (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle.
    always @(negedge clock) begin
        if (bus.valid_vote_casted === 1'b1) valid_seen++;
        if (bus.multi_press_error === 1'b1) error_seen++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [34:0] all_outputs();
        return {bus.valid_vote_casted, bus.multi_press_error, bus.busy,
                bus.candidate1_vote, bus.candidate2_vote,
                bus.candidate3_vote, bus.candidate4_vote};
    endfunction

    function automatic logic [31:0] tallies();
        return {bus.candidate1_vote, bus.candidate2_vote,
                bus.candidate3_vote, bus.candidate4_vote};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.mode        = 1'b0;
        bus.button1_raw = 1'b0;
        bus.button2_raw = 1'b0;
        bus.button3_raw = 1'b0;
        bus.button4_raw = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        #2 reset = 1'b0;
        step(2);
        #2 reset = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (all_outputs() !== 35'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", all_outputs(), 35'h0);
        end
        step(2);
        #2 reset = 1'b1;
        step(3);
        vectors++;
        if (all_outputs() !== 35'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_release_outputs: got %h expected %h", all_outputs(), 35'h0);
        end
    endtask

    task automatic test_single_vote();
        int  v0;
        logic exp_valid;
        apply_reset();
        v0 = valid_seen;
        bus.button2_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            exp_valid = (i == 7);
            vectors++;
            if (bus.valid_vote_casted !== exp_valid) begin
                miscompares++;
                $display("[TB] FAIL latency_edge%0d: valid got %b expected %b",
                         i - 1, bus.valid_vote_casted, exp_valid);
            end
        end
        vectors++;
        if (tallies() !== {8'd0, 8'd1, 8'd0, 8'd0}) begin
            miscompares++;
            $display("[TB] FAIL single_tallies: got %h expected %h", tallies(), {8'd0, 8'd1, 8'd0, 8'd0});
        end
        step(13);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_busy_held: got %b expected 1", bus.busy);
        end
        bus.button2_raw = 1'b0;
        step(8);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_busy_released: got %b expected 0", bus.busy);
        end
        vectors++;
        if (valid_seen - v0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL single_pulse_count: got %0d expected 1", valid_seen - v0);
        end
    endtask

    task automatic test_bounce();
        int v0;
        apply_reset();
        v0 = valid_seen;
        for (int i = 0; i < 12; i++) begin
            bus.button1_raw = (i % 2 == 0);
            step(1);
        end
        bus.button1_raw = 1'b0;
        step(8);
        vectors++;
        if (valid_seen - v0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL bounce_pulses: got %0d expected 0", valid_seen - v0);
        end
        vectors++;
        if (tallies() !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL bounce_tallies: got %h expected %h", tallies(), 32'h0);
        end
        for (int i = 0; i < 12; i++) begin
            bus.button1_raw = (i % 2 == 0);
            step(1);
        end
        bus.button1_raw = 1'b1;
        step(6);
        bus.button1_raw = 1'b0;
        step(4);
        vectors++;
        if (bus.candidate1_vote !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL bounce_then_hold: got %0d expected 1", bus.candidate1_vote);
        end
        step(20);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bounce_idle: busy got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_lockout_and_multi();
        int   v0;
        int   e0;
        logic exp_err;
        apply_reset();
        v0 = valid_seen;
        bus.button3_raw = 1'b1;
        step(8);
        bus.button4_raw = 1'b1;
        step(10);
        bus.button3_raw = 1'b0;
        bus.button4_raw = 1'b0;
        step(20);
        vectors++;
        if (tallies() !== {8'd0, 8'd0, 8'd1, 8'd0}) begin
            miscompares++;
            $display("[TB] FAIL lockout_tallies: got %h expected %h", tallies(), {8'd0, 8'd0, 8'd1, 8'd0});
        end
        vectors++;
        if (valid_seen - v0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL lockout_pulses: got %0d expected 1", valid_seen - v0);
        end
        e0 = error_seen;
        bus.button1_raw = 1'b1;
        bus.button2_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            exp_err = (i == 7);
            vectors++;
            if (bus.multi_press_error !== exp_err) begin
                miscompares++;
                $display("[TB] FAIL multi_err_edge%0d: got %b expected %b",
                         i - 1, bus.multi_press_error, exp_err);
            end
        end
        step(10);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL multi_busy_both: got %b expected 1", bus.busy);
        end
        vectors++;
        if (tallies() !== {8'd0, 8'd0, 8'd1, 8'd0}) begin
            miscompares++;
            $display("[TB] FAIL multi_tallies: got %h expected %h", tallies(), {8'd0, 8'd0, 8'd1, 8'd0});
        end
        bus.button1_raw = 1'b0;
        step(6);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL multi_busy_one_held: got %b expected 1", bus.busy);
        end
        bus.button2_raw = 1'b0;
        step(6);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL multi_busy_released: got %b expected 0", bus.busy);
        end
        vectors++;
        if ((error_seen - e0 !== 1) || (valid_seen - v0 !== 1)) begin
            miscompares++;
            $display("[TB] FAIL multi_pulse_counts: errors %0d valids %0d expected 1 and 1",
                     error_seen - e0, valid_seen - v0);
        end
    endtask

    task automatic test_mode();
        int v0;
        apply_reset();
        v0 = valid_seen;
        bus.mode = 1'b1;
        bus.button4_raw = 1'b1;
        step(10);
        bus.button4_raw = 1'b0;
        step(6);
        vectors++;
        if ((valid_seen - v0 !== 0) || (bus.candidate4_vote !== 8'd0) || (bus.busy !== 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL mode1_ignored: pulses %0d c4 %0d busy %b expected 0 0 0",
                     valid_seen - v0, bus.candidate4_vote, bus.busy);
        end
        bus.mode = 1'b0;
        bus.button4_raw = 1'b1;
        step(8);
        bus.mode = 1'b1;
        bus.button4_raw = 1'b0;
        step(20);
        vectors++;
        if (bus.candidate4_vote !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL mode0_vote: got %0d expected 1", bus.candidate4_vote);
        end
        vectors++;
        if ((bus.busy !== 1'b0) || (valid_seen - v0 !== 1)) begin
            miscompares++;
            $display("[TB] FAIL mode_switch_completes: busy %b pulses %0d expected 0 and 1",
                     bus.busy, valid_seen - v0);
        end
        bus.mode = 1'b0;
    endtask

    task automatic test_saturation();
        int v0;
        apply_reset();
        v0 = valid_seen;
        for (int s = 1; s <= 257; s++) begin
            bus.button1_raw = 1'b1;
            step(8);
            bus.button1_raw = 1'b0;
            step(16);
            if (s == 254) begin
                vectors++;
                if (bus.candidate1_vote !== 8'hFE) begin
                    miscompares++;
                    $display("[TB] FAIL sat_254: got %h expected FE", bus.candidate1_vote);
                end
            end
            if (s == 255) begin
                vectors++;
                if (bus.candidate1_vote !== 8'hFF) begin
                    miscompares++;
                    $display("[TB] FAIL sat_255: got %h expected FF", bus.candidate1_vote);
                end
            end
        end
        vectors++;
        if (bus.candidate1_vote !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL sat_257: got %h expected FF", bus.candidate1_vote);
        end
        vectors++;
        if (valid_seen - v0 !== 257) begin
            miscompares++;
            $display("[TB] FAIL sat_pulses: got %0d expected 257", valid_seen - v0);
        end
    endtask

    task automatic test_async_reset();
        int v0;
        apply_reset();
        bus.button2_raw = 1'b1;
        step(10);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (all_outputs() !== 35'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_outputs: got %h expected %h", all_outputs(), 35'h0);
        end
        bus.button2_raw = 1'b0;
        step(2);
        v0 = valid_seen;
        #2 reset = 1'b1;
        step(15);
        vectors++;
        if ((valid_seen - v0 !== 0) || (bus.busy !== 1'b0) || (tallies() !== 32'h0)) begin
            miscompares++;
            $display("[TB] FAIL async_reset_quiet: pulses %0d busy %b tallies %h expected 0 0 0",
                     valid_seen - v0, bus.busy, tallies());
        end
        bus.button3_raw = 1'b1;
        step(8);
        bus.button3_raw = 1'b0;
        step(20);
        vectors++;
        if ((tallies() !== {8'd0, 8'd0, 8'd1, 8'd0}) || (valid_seen - v0 !== 1)) begin
            miscompares++;
            $display("[TB] FAIL async_reset_next_vote: tallies %h pulses %0d expected %h and 1",
                     tallies(), valid_seen - v0, {8'd0, 8'd0, 8'd1, 8'd0});
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_vote();
        test_bounce();
        test_lockout_and_multi();
        test_mode();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
